int_dispatch_sched: RTL and testbench

//  Dispatch scheduler between the interrupt controller and a pool of NUM_HANDLERS service engines.

---
 rtl/int_cntrl_pkg.sv | 13 +
 rtl/rr_free_pick.sv | 24 ++
 rtl/int_dispatch_sched.sv | 118 +++++++++++
 tb/tb_int_dispatch_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/int_cntrl_pkg.sv
// rtl/int_cntrl_pkg.sv - shared types and defaults for the interrupt dispatch scheduler
package int_cntrl_pkg;

    localparam int NUM_PERIPHS_DEF = 16;

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0001,
        S_DISPATCH  = 4'b0010,
        S_RELEASE   = 4'b0100,
        S_WAIT_DROP = 4'b1000
    } state_t;

endpackage

// File: rtl/rr_free_pick.sv
// rtl/rr_free_pick.sv - first free handler at or after rr_ptr, wrapping
module rr_free_pick #(
    parameter int NUM_HANDLERS = 4,
    parameter int HID_W        = $clog2(NUM_HANDLERS)
) (
    input  logic [NUM_HANDLERS-1:0] busy,
    input  logic [HID_W-1:0]        rr_ptr,
    output logic                    any_free,
    output logic [HID_W-1:0]        pick
);

    // Scan from the farthest offset down so the nearest free handler wins.
    always_comb begin
        any_free = 1'b0;
        pick     = '0;
        for (int i = NUM_HANDLERS - 1; i >= 0; i--) begin
            if (!busy[HID_W'((int'(rr_ptr) + i) % NUM_HANDLERS)]) begin
                any_free = 1'b1;
                pick     = HID_W'((int'(rr_ptr) + i) % NUM_HANDLERS);
            end
        end
    end

endmodule

// File: rtl/int_dispatch_sched.sv
// rtl/int_dispatch_sched.sv - round-robin dispatch of pending interrupt vectors to handler engines
module int_dispatch_sched
    import int_cntrl_pkg::*;
#(
    parameter int NUM_PERIPHS  = NUM_PERIPHS_DEF,
    parameter int IDX_W        = $clog2(NUM_PERIPHS),
    parameter int NUM_HANDLERS = 4,
    parameter int HID_W        = $clog2(NUM_HANDLERS),
    parameter int ACK_TIMEOUT  = 255,
    parameter int TO_W         = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                    pclk_i,
    input  logic                    prst_n_i,
    input  logic                    int_valid_i,
    input  logic [IDX_W-1:0]        int_to_service_i,
    output logic                    int_serviced_o,
    output logic [NUM_HANDLERS-1:0] hdl_req_o,
    output logic [IDX_W-1:0]        hdl_vec_o,
    input  logic [NUM_HANDLERS-1:0] hdl_ack_i,
    input  logic [NUM_HANDLERS-1:0] hdl_done_i,
    output logic [NUM_HANDLERS-1:0] busy_o,
    output logic                    timeout_o,
    output logic [HID_W-1:0]        timeout_hid_o
);

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        vec_q;
    logic [HID_W-1:0]        gnt_q, gnt_inc, rr_ptr, pick;
    logic [NUM_HANDLERS-1:0] busy, set_mask;
    logic [TO_W-1:0]         timer;
    logic                    any_free, launch, acked, expired;

    rr_free_pick #(
        .NUM_HANDLERS(NUM_HANDLERS),
        .HID_W       (HID_W)
    ) u_pick (
        .busy    (busy),
        .rr_ptr  (rr_ptr),
        .any_free(any_free),
        .pick    (pick)
    );

    assign gnt_inc = (gnt_q == HID_W'(NUM_HANDLERS - 1)) ? '0 : gnt_q + 1'b1;
    assign busy_o  = busy;

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) state <= S_IDLE;
        else           state <= state_nx;
    end

    // Ack outranks withdraw, and withdraw outranks an expiring timer.
    always_comb begin
        state_nx       = state;
        launch         = 1'b0;
        acked          = 1'b0;
        expired        = 1'b0;
        set_mask       = '0;
        hdl_req_o      = '0;
        hdl_vec_o      = '0;
        int_serviced_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (int_valid_i && any_free) begin
                    launch   = 1'b1;
                    state_nx = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                hdl_req_o[gnt_q] = 1'b1;
                hdl_vec_o        = vec_q;
                if (hdl_ack_i[gnt_q]) begin
                    acked           = 1'b1;
                    set_mask[gnt_q] = 1'b1;
                    state_nx        = S_RELEASE;
                end else if (!int_valid_i) begin
                    state_nx = S_IDLE;
                end else if (timer == TO_W'(ACK_TIMEOUT - 1)) begin
                    expired  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_RELEASE: begin
                int_serviced_o = 1'b1;
                state_nx       = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                if (!int_valid_i) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            vec_q         <= '0;
            gnt_q         <= '0;
            rr_ptr        <= '0;
            busy          <= '0;
            timer         <= '0;
            timeout_o     <= 1'b0;
            timeout_hid_o <= '0;
        end else begin
            if (launch) begin
                vec_q <= int_to_service_i;
                gnt_q <= pick;
                timer <= '0;
            end else if (state == S_DISPATCH) begin
                timer <= timer + 1'b1;
            end
            if (acked || expired) rr_ptr <= gnt_inc;
            // A set from an ack beats a coincident done on the same handler.
            busy      <= (busy & ~hdl_done_i) | set_mask;
            timeout_o <= expired;
            if (expired) timeout_hid_o <= gnt_q;
        end
    end

endmodule

// File: tb/tb_int_dispatch_sched.sv
// tb/tb_int_dispatch_sched.sv - directed vector bench for int_dispatch_sched
module tb_int_dispatch_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       int_valid = 1'b0;
    logic [3:0] int_vec = '0;
    logic       serviced;
    logic [3:0] req;
    logic [3:0] hvec;
    logic [3:0] ack = '0;
    logic [3:0] done = '0;
    logic [3:0] busy;
    logic       tmo;
    logic [1:0] tmo_hid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    int_dispatch_sched #(
        .NUM_PERIPHS (16),
        .NUM_HANDLERS(4),
        .ACK_TIMEOUT (4)
    ) dut (
        .pclk_i          (clk),
        .prst_n_i        (rst_n),
        .int_valid_i     (int_valid),
        .int_to_service_i(int_vec),
        .int_serviced_o  (serviced),
        .hdl_req_o       (req),
        .hdl_vec_o       (hvec),
        .hdl_ack_i       (ack),
        .hdl_done_i      (done),
        .busy_o          (busy),
        .timeout_o       (tmo),
        .timeout_hid_o   (tmo_hid)
    );

    typedef struct {
        logic       rn;
        logic       v;
        logic [3:0] vec;
        logic [3:0] ack;
        logic [3:0] done;
        logic [3:0] req;
        logic [3:0] hvec;
        logic       srv;
        logic [3:0] busy;
        logic       to;
    } tv_t;

    tv_t tbl[$];

    function automatic tv_t row(input logic rn, v, input logic [3:0] vec, ack, done, req, hvec,
                                input logic srv, input logic [3:0] bsy, input logic to);
        tv_t r;
        r.rn = rn; r.v = v; r.vec = vec; r.ack = ack; r.done = done;
        r.req = req; r.hvec = hvec; r.srv = srv; r.busy = bsy; r.to = to;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] vec, input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        int_valid = v;
        int_vec   = vec;
        ack       = a;
        done      = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; int_valid = 1'b0; ack = '0; done = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //         rn v vec  ack      done     req      hvec srv busy     to
        tbl.push_back(row(0, 0, 0, 0,       0,       0,       0, 0, 0,       0));
        tbl.push_back(row(1, 1, 5, 0,       0,       0,       0, 0, 0,       0));
        tbl.push_back(row(1, 1, 5, 4'b0001, 0,       4'b0001, 5, 0, 0,       0));
        tbl.push_back(row(1, 1, 5, 0,       0,       0,       0, 1, 4'b0001, 0));
        tbl.push_back(row(1, 1, 5, 0,       0,       0,       0, 0, 4'b0001, 0));
        tbl.push_back(row(1, 1, 5, 0,       0,       0,       0, 0, 4'b0001, 0));
        tbl.push_back(row(1, 0, 0, 0,       0,       0,       0, 0, 4'b0001, 0));
        tbl.push_back(row(0, 0, 0, 0,       0,       0,       0, 0, 0,       0));
        tbl.push_back(row(1, 1, 3, 0,       0,       0,       0, 0, 0,       0));
        tbl.push_back(row(1, 1, 3, 4'b0001, 0,       4'b0001, 3, 0, 0,       0));
        tbl.push_back(row(1, 1, 3, 0,       0,       0,       0, 1, 4'b0001, 0));
        tbl.push_back(row(1, 0, 0, 0,       4'b0100, 0,       0, 0, 4'b0001, 0));
        tbl.push_back(row(1, 1, 7, 0,       0,       0,       0, 0, 4'b0001, 0));
        tbl.push_back(row(1, 1, 7, 4'b0110, 0,       4'b0010, 7, 0, 4'b0001, 0));
        tbl.push_back(row(1, 1, 7, 0,       0,       0,       0, 1, 4'b0011, 0));
        tbl.push_back(row(1, 0, 0, 0,       0,       0,       0, 0, 4'b0011, 0));
        tbl.push_back(row(1, 1, 9, 0,       0,       0,       0, 0, 4'b0011, 0));
        tbl.push_back(row(1, 1, 9, 4'b0100, 0,       4'b0100, 9, 0, 4'b0011, 0));
        tbl.push_back(row(1, 1, 9, 0,       0,       0,       0, 1, 4'b0111, 0));
        tbl.push_back(row(1, 0, 0, 0,       0,       0,       0, 0, 4'b0111, 0));
        tbl.push_back(row(1, 1, 1, 0,       0,       0,       0, 0, 4'b0111, 0));
        tbl.push_back(row(1, 1, 1, 4'b1000, 0,       4'b1000, 1, 0, 4'b0111, 0));
        tbl.push_back(row(1, 1, 1, 0,       0,       0,       0, 1, 4'b1111, 0));
        tbl.push_back(row(1, 0, 0, 0,       0,       0,       0, 0, 4'b1111, 0));
        tbl.push_back(row(1, 1, 4, 0,       0,       0,       0, 0, 4'b1111, 0));
        tbl.push_back(row(1, 1, 4, 0,       0,       0,       0, 0, 4'b1111, 0));
        tbl.push_back(row(1, 1, 4, 0,       4'b0100, 0,       0, 0, 4'b1111, 0));
        tbl.push_back(row(1, 1, 4, 0,       0,       0,       0, 0, 4'b1011, 0));
        tbl.push_back(row(1, 1, 4, 4'b0100, 0,       4'b0100, 4, 0, 4'b1011, 0));
        tbl.push_back(row(1, 1, 4, 0,       0,       0,       0, 1, 4'b1111, 0));
        tbl.push_back(row(1, 0, 0, 0,       0,       0,       0, 0, 4'b1111, 0));

        repeat (2) @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_n     = tbl[i].rn;
            int_valid = tbl[i].v;
            int_vec   = tbl[i].vec;
            ack       = tbl[i].ack;
            done      = tbl[i].done;
            #1;
            chk($sformatf("row%0d req", i),  32'(req),      32'(tbl[i].req));
            chk($sformatf("row%0d vec", i),  32'(hvec),     32'(tbl[i].hvec));
            chk($sformatf("row%0d srv", i),  32'(serviced), 32'(tbl[i].srv));
            chk($sformatf("row%0d busy", i), 32'(busy),     32'(tbl[i].busy));
            chk($sformatf("row%0d tmo", i),  32'(tmo),      32'(tbl[i].to));
        end

        // Withdraw: request disappears, no pulse, rr_ptr stays at 0
        do_reset();
        cyc(1, 6, 0, 0);       chk("wd idle req", 32'(req), 0);
        cyc(1, 6, 0, 0);       chk("wd req", 32'(req), 32'h1); chk("wd vec", 32'(hvec), 6);
        cyc(0, 0, 0, 0);       chk("wd req hold", 32'(req), 32'h1);
        cyc(0, 0, 0, 0);       chk("wd req gone", 32'(req), 0); chk("wd no srv", 32'(serviced), 0);
                               chk("wd busy", 32'(busy), 0);
        cyc(1, 8, 0, 0);       chk("wd2 idle", 32'(req), 0);
        cyc(1, 8, 4'b0001, 0); chk("wd rr unchanged", 32'(req), 32'h1); chk("wd2 vec", 32'(hvec), 8);
        cyc(1, 8, 0, 0);       chk("wd2 srv", 32'(serviced), 1); chk("wd2 busy", 32'(busy), 32'h1);
        cyc(0, 0, 0, 0);       chk("wd2 srv off", 32'(serviced), 0);

        // Timeout: handler 1 never acks, retry goes to handler 2
        cyc(1, 10, 0, 0);      chk("to idle", 32'(req), 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 10, 4'b1101, 0);
            chk($sformatf("to req%0d", k), 32'(req), 32'h2);
            chk($sformatf("to vec%0d", k), 32'(hvec), 10);
            chk($sformatf("to early%0d", k), 32'(tmo), 0);
        end
        cyc(1, 10, 0, 0);      chk("to pulse", 32'(tmo), 1); chk("to hid", 32'(tmo_hid), 1);
                               chk("to req off", 32'(req), 0); chk("to busy", 32'(busy), 32'h1);
        cyc(1, 10, 0, 0);      chk("to retry req", 32'(req), 32'h4); chk("to pulse end", 32'(tmo), 0);
                               chk("to hid hold", 32'(tmo_hid), 1);
        cyc(1, 10, 4'b0100, 0); chk("to retry req2", 32'(req), 32'h4);
        cyc(1, 10, 0, 0);      chk("to retry srv", 32'(serviced), 1); chk("to retry busy", 32'(busy), 32'h5);
        cyc(0, 0, 0, 0);

        // Reset while a request is up
        cyc(1, 2, 0, 0);       chk("rst idle", 32'(req), 0);
        cyc(1, 2, 0, 0);       chk("rst req", 32'(req), 32'h8); chk("rst pre vec", 32'(hvec), 2);
        rst_n = 1'b0; #1;
        chk("rst req drop", 32'(req), 0); chk("rst vec", 32'(hvec), 0);
        chk("rst busy", 32'(busy), 0);    chk("rst srv", 32'(serviced), 0);
        chk("rst hid", 32'(tmo_hid), 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;

        // Reset during the serviced pulse
        cyc(1, 12, 0, 0);
        cyc(1, 12, 4'b0001, 0); chk("rst2 req", 32'(req), 32'h1);
        cyc(1, 12, 0, 0);       chk("rst2 srv on", 32'(serviced), 1);
        rst_n = 1'b0; #1;
        chk("rst2 srv off", 32'(serviced), 0); chk("rst2 busy", 32'(busy), 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
